// File: rtl/cla_pkg.sv
// Shared constants, FSM state type and sizing helper
// for the nibble-serial adder.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int idx_width(input int width);
    int n;
    n = width / NIBBLE;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice with group
// propagate/generate and the carry into bit 3.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co,
  output logic       cp,
  output logic       pi,
  output logic       gi
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = gi | (pi & ci);

  assign pi = &p;
  assign gi = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign sum = p ^ c[3:0];
  assign co  = c[4];
  assign cp  = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder reusing one 4-bit CLA slice, one nibble
// per clock, LSB first, with valid/ready on both sides.
module nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IW-1:0]    idx;

  logic [3:0] s_a;
  logic [3:0] s_b;
  logic [3:0] s_sum;
  logic       s_co;
  logic       s_cp;
  logic       unused_pi;
  logic       unused_gi;
  logic       accept;
  logic       last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == LAST);

  assign s_a = a_reg[{idx, 2'b00} +: NIBBLE];
  assign s_b = b_reg[{idx, 2'b00} +: NIBBLE];

  cla4_slice u_slice (
    .a   (s_a),
    .b   (s_b),
    .ci  (carry_reg),
    .sum (s_sum),
    .co  (s_co),
    .cp  (s_cp),
    .pi  (unused_pi),
    .gi  (unused_gi)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        idx       <= '0;
      end
      if (state == RUN) begin
        sum_reg[{idx, 2'b00} +: NIBBLE] <= s_sum;
        carry_reg <= s_co;
        idx       <= last ? '0 : idx + 1'b1;
        // Final slice carries decide cout and signed overflow
        if (last) begin
          cout_reg <= s_co;
          ovf_reg  <= s_co ^ s_cp;
        end
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder
// (WIDTH=16 main instance, WIDTH=4 corner instance).
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       out_valid4;
  logic       out_ready4 = 1'b0;
  logic [3:0] sum4;
  logic       cout4;
  logic       ovf4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] av,
                          input logic [15:0] bv,
                          input logic c,
                          input string nm);
    a = av;
    b = bv;
    cin = c;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready got=%b exp=1", nm, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input string nm);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != exp_lat) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", nm, n, exp_lat);
    end
  endtask

  task automatic check_res(input logic [15:0] es,
                           input logic ec,
                           input logic eo,
                           input string nm);
    checks++;
    if (sum !== es || cout !== ec || ovf !== eo) begin
      errors++;
      $display("FAIL %s got sum=%h c=%b o=%b exp sum=%h c=%b o=%b",
               nm, sum, cout, ovf, es, ec, eo);
    end
  endtask

  task automatic pop(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s pop got ov=%b ir=%b exp ov=0 ir=1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic add16(input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic [15:0] es,
                       input logic ec, input logic eo,
                       input string nm);
    start_op(av, bv, c, nm);
    wait_done(4, nm);
    check_res(es, ec, eo, nm);
    pop(nm);
  endtask

  task automatic reset_pulse(input string nm);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s got ov=%b ir=%b sum=%h c=%b o=%b exp 0 1 0000 0 0",
               nm, out_valid, in_ready, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0 ||
        cout !== 1'b0 || ovf !== 1'b0 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got ov=%b ir=%b sum=%h exp 0 1 0000",
               out_valid, in_ready, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    reset_pulse("reset_idle");
    start_op(16'h8000, 16'h8000, 1'b0, "reset_run");
    reset_pulse("reset_run");
    start_op(16'h7FFF, 16'h0001, 1'b0, "reset_done");
    wait_done(4, "reset_done");
    check_res(16'h8000, 1'b0, 1'b1, "reset_done_res");
    @(posedge clk);
    reset_pulse("reset_done");
  endtask

  task automatic test_basic();
    add16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_ripple();
    add16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_b");
    add16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple_cin");
  endtask

  task automatic test_overflow();
    add16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    add16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
  endtask

  task automatic test_back_to_back();
    start_op(16'h1234, 16'h4321, 1'b0, "bp_first");
    wait_done(4, "bp_first");
    a = 16'h0F0F;
    b = 16'h00F1;
    cin = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0 ||
          in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got sum=%h ir=%b ov=%b exp 5555 0 1",
                 i, sum, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ir=%b ov=%b exp 1 0",
               in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got ir=%b exp 0", in_ready);
    end
    wait_done(4, "bp_second");
    check_res(16'h1001, 1'b0, 1'b0, "bp_second");
    pop("bp_second");
  endtask

  task automatic test_reset_mid_run();
    start_op(16'hAAAA, 16'h5555, 1'b0, "mid_run");
    tick();
    reset_pulse("mid_run_rst");
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (out_valid !== 1'b0) seen++;
        tick();
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL mid_run_no_out got=%0d exp=0", seen);
      end
    end
    add16(16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_width4();
    int n;
    a4 = 4'h9;
    b4 = 4'h8;
    cin4 = 1'b0;
    in_valid4 = 1'b1;
    checks++;
    if (in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL w4_ready got=%b exp=1", in_ready4);
    end
    tick();
    in_valid4 = 1'b0;
    n = 0;
    while (out_valid4 !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid4 !== 1'b1 || n != 1) begin
      errors++;
      $display("FAIL w4_latency got=%0d exp=1", n);
    end
    checks++;
    if (sum4 !== 4'h1 || cout4 !== 1'b1 || ovf4 !== 1'b1) begin
      errors++;
      $display("FAIL w4_result got sum=%h c=%b o=%b exp 1 1 1",
               sum4, cout4, ovf4);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL w4_pop got ov=%b ir=%b exp 0 1",
               out_valid4, in_ready4);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_width4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
